// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - miniRV hazard/forwarding controller; forwarding enabled by HAZARD_FWD_EN
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Destination record of one in-flight instruction
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } shadow_t;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_next;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic raw_stall;
  logic eff_stall;
  logic redirect;
  logic [1:0] fwd1_raw, fwd2_raw;
  logic unused_bits;

  // A stage satisfies a source only if it really writes a non-zero register that ID reads
  function automatic logic hit(input shadow_t s, input logic [4:0] rs, input logic re,
                               input logic valid);
    return valid && re && s.v && s.we && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

  // Compare every shadow stage against both ID sources
  always_comb begin
    ex_hit1  = hit(ex_q,  id_rs1, id_re1, id_valid);
    ex_hit2  = hit(ex_q,  id_rs2, id_re2, id_valid);
    mem_hit1 = hit(mem_q, id_rs1, id_re1, id_valid);
    mem_hit2 = hit(mem_q, id_rs2, id_re2, id_valid);
    wb_hit1  = hit(wb_q,  id_rs1, id_re1, id_valid);
    wb_hit2  = hit(wb_q,  id_rs2, id_re2, id_valid);
  end

`ifdef HAZARD_FWD_EN
  // Youngest producer wins so the operand reflects the latest write
  function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
    if (e) return 2'b01;
    if (m) return 2'b10;
    if (w) return 2'b11;
    return 2'b00;
  endfunction

  // Only a load still in EX cannot be bypassed; everything else forwards
  always_comb begin
    fwd1_raw  = pick(ex_hit1, mem_hit1, wb_hit1);
    fwd2_raw  = pick(ex_hit2, mem_hit2, wb_hit2);
    raw_stall = ex_q.ld && (ex_hit1 || ex_hit2);
  end
`else
  // Without bypass paths every RAW match waits until the producer retires from WB
  always_comb begin
    fwd1_raw  = 2'b00;
    fwd2_raw  = 2'b00;
    raw_stall = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2 || wb_hit1 || wb_hit2;
  end
`endif

  // A redirect kills the ID instruction, so it overrides any stall; reset silences everything
  always_comb begin
    redirect    = rst_n && ex_redirect;
    eff_stall   = rst_n && raw_stall && !ex_redirect;
    pc_stall    = eff_stall;
    if_id_stall = eff_stall;
    if_id_flush = redirect;
    id_ex_flush = eff_stall || redirect;
    fwd_rs1     = rst_n ? fwd1_raw : 2'b00;
    fwd_rs2     = rst_n ? fwd2_raw : 2'b00;
  end

  // Record entering EX: the ID instruction, or a bubble when it is stalled or flushed
  always_comb begin
    ex_next = '0;
    if (id_valid && !id_ex_flush) begin
      ex_next.v  = 1'b1;
      ex_next.rd = id_rd;
      ex_next.we = id_rf_we;
      ex_next.ld = id_is_load;
    end
  end

  // Load flags past EX are carried for completeness but not consulted
  assign unused_bits = ^{mem_q.ld, wb_q.ld};

  // Advance the shadow pipeline and update the saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_next;
      if (eff_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with an age-ordered reference model
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_re1, id_re2, id_rf_we, id_is_load;
  logic             ex_redirect;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic [1:0]       fwd_rs1, fwd_rs2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions ordered by age (0 = one stage past ID)
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } rec_t;

  rec_t inflight[$];
  int   m_stall_cnt = 0;
  int   m_flush_cnt = 0;

  function automatic bit reads(input rec_t r, input int rs, input bit re);
    return id_valid && re && r.v && r.we && r.rd != 0 && r.rd == rs;
  endfunction

  // Hazard verdict from the rules: forwarding code is age+1 of the youngest producer
  function automatic void model_eval(output bit st, output int f1, output int f2);
    bit any_hit;
    bit load_hit;
    bit h1, h2;
    rec_t r;
    any_hit = 0; load_hit = 0; f1 = 0; f2 = 0;
    for (int age = 0; age < inflight.size(); age++) begin
      r  = inflight[age];
      h1 = reads(r, int'(id_rs1), id_re1);
      h2 = reads(r, int'(id_rs2), id_re2);
      if (h1 && f1 == 0) f1 = age + 1;
      if (h2 && f2 == 0) f2 = age + 1;
      if (h1 || h2) begin
        any_hit = 1;
        if (age == 0 && r.ld) load_hit = 1;
      end
    end
`ifdef HAZARD_FWD_EN
    st = load_hit;
`else
    st = any_hit;
    f1 = 0;
    f2 = 0;
`endif
  endfunction

  // Model state update on each rising edge
  always @(posedge clk) begin
    bit st;
    int f1, f2;
    bit es;
    rec_t r;
    if (!rst_n) begin
      inflight.delete();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      model_eval(st, f1, f2);
      es   = st && !ex_redirect;
      r.v  = id_valid && !(es || ex_redirect);
      r.rd = int'(id_rd);
      r.we = id_rf_we;
      r.ld = id_is_load;
      inflight.push_front(r);
      if (inflight.size() > 3) void'(inflight.pop_back());
      if (es && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (ex_redirect && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit st;
    int f1, f2;
    bit es, rd;
    model_eval(st, f1, f2);
    if (!rst_n) begin
      es = 0; rd = 0; f1 = 0; f2 = 0;
    end else begin
      rd = ex_redirect;
      es = st && !ex_redirect;
    end
    chk("pc_stall",    pc_stall,    es);
    chk("if_id_stall", if_id_stall, es);
    chk("if_id_flush", if_id_flush, rd);
    chk("id_ex_flush", id_ex_flush, es || rd);
    chk("fwd_rs1",     fwd_rs1,     f1);
    chk("fwd_rs2",     fwd_rs2,     f2);
    chk("stall_cnt",   stall_cnt,   m_stall_cnt);
    chk("flush_cnt",   flush_cnt,   m_flush_cnt);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit re1, input bit re2,
                        input int rd, input bit we, input bit ld);
    id_valid   = v;
    id_rs1     = 5'(rs1);
    id_rs2     = 5'(rs2);
    id_re1     = re1;
    id_re2     = re2;
    id_rd      = 5'(rd);
    id_rf_we   = we;
    id_is_load = ld;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    ex_redirect = 1'b1;
    set_id(1, 5, 5, 1, 1, 5, 1, 1);

    // Reset held with redirect and live ID inputs: everything quiet
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("rst_pc_stall", pc_stall, 0);
      chk("rst_if_id_flush", if_id_flush, 0);
      chk("rst_id_ex_flush", id_ex_flush, 0);
      chk("rst_fwd_rs1", fwd_rs1, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
    end
    rst_n       = 1'b1;
    ex_redirect = 1'b0;
    set_id(0, 5, 5, 1, 1, 5, 1, 0);
    next_cyc();
    at_neg();
    chk("post_rst_stall", pc_stall, 0);
    chk("post_rst_fwd", fwd_rs1, 0);
    chk("post_rst_cnt", stall_cnt, 0);

    // add x5 then add x6,x5,x5
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    next_cyc();
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    at_neg();
`ifdef HAZARD_FWD_EN
    chk("d1_fwd1", fwd_rs1, 1);
    chk("d1_fwd2", fwd_rs2, 1);
    chk("d1_stall", pc_stall, 0);
`else
    chk("d1_stall_a", pc_stall, 1);
    next_cyc(); at_neg();
    chk("d1_stall_b", pc_stall, 1);
    next_cyc(); at_neg();
    chk("d1_stall_c", pc_stall, 1);
    next_cyc(); at_neg();
    chk("d1_release", pc_stall, 0);
    chk("d1_stall_cnt", stall_cnt, 3);
`endif

    // One and two unrelated slots between producer and consumer
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    next_cyc();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    at_neg();
`ifdef HAZARD_FWD_EN
    chk("d2_fwd1", fwd_rs1, 2);
    chk("d2_fwd2", fwd_rs2, 2);
`else
    chk("d2_stall", pc_stall, 1);
`endif
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    next_cyc();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    next_cyc();
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    at_neg();
`ifdef HAZARD_FWD_EN
    chk("d3_fwd1", fwd_rs1, 3);
    chk("d3_stall", pc_stall, 0);
`else
    chk("d3_stall", pc_stall, 1);
`endif

    // lw x5 then add x6,x5,x0
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    next_cyc();
    set_id(1, 5, 0, 1, 1, 6, 1, 0);
    at_neg();
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_if_id_stall", if_id_stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_if_id_flush", if_id_flush, 0);
    next_cyc(); at_neg();
`ifdef HAZARD_FWD_EN
    chk("lu_release", pc_stall, 0);
    chk("lu_fwd1", fwd_rs1, 2);
    chk("lu_fwd2", fwd_rs2, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
`else
    chk("lu_stall_b", pc_stall, 1);
    next_cyc(); at_neg();
    chk("lu_stall_c", pc_stall, 1);
    next_cyc(); at_neg();
    chk("lu_release", pc_stall, 0);
    chk("lu_fwd1", fwd_rs1, 0);
    chk("lu_stall_cnt", stall_cnt, 3);
`endif

    // Load-use coinciding with a redirect
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    next_cyc();
    set_id(1, 5, 0, 1, 1, 6, 1, 0);
    ex_redirect = 1'b1;
    at_neg();
    chk("rd_if_id_flush", if_id_flush, 1);
    chk("rd_id_ex_flush", id_ex_flush, 1);
    chk("rd_pc_stall", pc_stall, 0);
    chk("rd_if_id_stall", if_id_stall, 0);
    next_cyc();
    ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("rd_stall_cnt", stall_cnt, 0);
    chk("rd_flush_cnt", flush_cnt, 1);

    // x0 is never a hazard
    do_reset();
    set_id(1, 1, 2, 1, 1, 0, 1, 0);
    next_cyc();
    set_id(1, 0, 0, 1, 1, 7, 1, 0);
    at_neg();
    chk("x0_stall", pc_stall, 0);
    chk("x0_fwd1", fwd_rs1, 0);
    next_cyc(); at_neg();
    chk("x0_stall_b", pc_stall, 0);
    chk("x0_fwd2", fwd_rs2, 0);

    // 20 back-to-back redirects saturate a 4-bit counter
    do_reset();
    ex_redirect = 1'b1;
    repeat (20) next_cyc();
    ex_redirect = 1'b0;
    at_neg();
    chk("sat_flush_cnt", flush_cnt, CNT_MAX);

    // Reset in the middle of a stall leaves no residue
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    next_cyc();
    set_id(1, 5, 0, 1, 1, 6, 1, 0);
    at_neg();
    chk("mid_stall", pc_stall, 1);
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    at_neg();
    chk("mid_rst_stall", pc_stall, 0);
    chk("mid_rst_cnt", stall_cnt, 0);

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      next_cyc();
    end

    at_neg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
